// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared entry type, PC alignment constants and helper for the fetch stage
package fetch_pkg;

    // Queue entries are sized for the widest supported configuration (XLEN <= 64, ILEN <= 32).
    localparam int FETCH_XLEN_MAX = 64;
    localparam int FETCH_ILEN_MAX = 32;
    localparam int INSTR_BYTES    = 4;

    localparam logic [FETCH_XLEN_MAX-1:0] PC_ALIGN_MASK = ~64'(INSTR_BYTES - 1);

    typedef struct packed {
        logic [FETCH_XLEN_MAX-1:0] pc;
        logic [FETCH_ILEN_MAX-1:0] instr;
    } fetch_entry_t;

    function automatic logic [FETCH_XLEN_MAX-1:0] align_pc(input logic [FETCH_XLEN_MAX-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetch_entry_t with flush, count, full and empty
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - fetch PC, single-outstanding imem requests and prefetch queue to decode
// Optional perf_fetched/perf_stall counters exist only when FETCH_PERF_COUNTERS_EN is defined.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [ILEN-1:0]  imem_rsp_instr,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [XLEN-1:0]  dec_pc,
    output logic [ILEN-1:0]  dec_instr
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]           fetch_pc;
    logic [XLEN-1:0]           req_pc;
    logic                      outstanding;
    logic                      drop;
    logic                      accept;
    logic                      rsp_take;
    logic                      push;
    logic                      pop;
    logic                      q_full;
    logic                      q_empty;
    logic [CW-1:0]             q_count;
    fetch_entry_t              push_entry;
    fetch_entry_t              head;
    logic [FETCH_XLEN_MAX-1:0] redirect_target;

    assign redirect_target = align_pc(FETCH_XLEN_MAX'(redirect_pc));

    // Issue only when a queue slot is guaranteed for the response.
    assign imem_req_valid = !rst && !redirect_valid && !outstanding && (q_count < CW'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_take = imem_rsp_valid && outstanding;
    assign push     = rsp_take && !drop && !redirect_valid && (!q_full || pop);
    assign pop      = dec_valid && dec_ready && !redirect_valid;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = FETCH_XLEN_MAX'(req_pc);
        push_entry.instr = FETCH_ILEN_MAX'(imem_rsp_instr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (rsp_take) outstanding <= 1'b0;
            if (accept) begin
                outstanding <= 1'b1;
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + XLEN'(INSTR_BYTES);
            end
            // A response still in flight at redirect belongs to the old stream.
            if (redirect_valid) begin
                fetch_pc <= redirect_target[XLEN-1:0];
                drop     <= outstanding && !imem_rsp_valid;
            end else if (rsp_take) begin
                drop <= 1'b0;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign dec_valid = !q_empty;
    assign dec_pc    = q_empty ? '0 : head.pc[XLEN-1:0];
    assign dec_instr = q_empty ? '0 : head.instr[ILEN-1:0];

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop)                    perf_fetched <= perf_fetched + 32'd1;
            if (dec_valid && !dec_ready) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - self-checking bench for fetch_prefetch_unit with a queue-level reference model
module tb_fetch_prefetch_unit;
    localparam int          XLEN    = 64;
    localparam int          ILEN    = 32;
    localparam int          DEPTH   = 4;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             redirect_valid = 1'b0;
    logic [XLEN-1:0]  redirect_pc    = '0;
    logic             imem_req_valid;
    logic             imem_req_ready = 1'b0;
    logic [XLEN-1:0]  imem_req_addr;
    logic             imem_rsp_valid = 1'b0;
    logic [ILEN-1:0]  imem_rsp_instr = '0;
    logic             dec_valid;
    logic             dec_ready      = 1'b0;
    logic [XLEN-1:0]  dec_pc;
    logic [ILEN-1:0]  dec_instr;

    logic             w_req_valid;
    logic             w_req_ready = 1'b0;
    logic [XLEN-1:0]  w_req_addr;
    logic             w_rsp_valid = 1'b0;
    logic [ILEN-1:0]  w_rsp_instr = '0;
    logic             w_dec_valid;
    logic             w_dec_ready = 1'b0;
    logic [XLEN-1:0]  w_dec_pc;
    logic [ILEN-1:0]  w_dec_instr;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

    fetch_prefetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC('0)) u_dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr)
`ifdef FETCH_PERF_COUNTERS_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    fetch_prefetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc('0),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_instr(w_rsp_instr),
        .dec_valid(w_dec_valid), .dec_ready(w_dec_ready), .dec_pc(w_dec_pc), .dec_instr(w_dec_instr)
`ifdef FETCH_PERF_COUNTERS_EN
        , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the expected queue contents as a list of PCs, plus the memory environment.
    logic [63:0] mq[$];
    logic [63:0] exp_req;
    int          epoch;
    bit          mem_busy;
    int          mem_cnt;
    int          mem_epoch;
    int          lat = 1;
    logic [63:0] mem_addr, mem_exp_pc;
    int unsigned m_fetched, m_stall;

    logic        e_req_valid, e_dec_valid, o_req_valid, o_dec_valid;
    logic [63:0] e_req_addr, e_dec_pc, o_req_addr, o_dec_pc;
    logic [31:0] e_dec_instr, o_dec_instr;
    logic        o_accept, o_pop, o_rsp;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'h13 ^ (pc[31:0] << 6) ^ pc[63:32];
    endfunction

    task automatic reset_model();
        mq.delete();
        exp_req        = '0;
        epoch          = epoch + 1;
        mem_busy       = 1'b0;
        mem_cnt        = 0;
        m_fetched      = 0;
        m_stall        = 0;
        imem_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b0;
        w_req_ready    = 1'b0;
        w_rsp_valid    = 1'b0;
        reset_model();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock: memory drives its response at negedge, outputs sampled 1 time unit later.
    task automatic step();
        bit accept_m, pop_m, push_m;
        @(negedge clk);
        imem_rsp_valid = mem_busy && (mem_cnt == 0);
        imem_rsp_instr = imem_rsp_valid ? instr_of(mem_addr) : 32'($urandom);
        #1;
        e_req_valid = !redirect_valid && !mem_busy && (mq.size() < DEPTH);
        e_req_addr  = exp_req;
        e_dec_valid = mq.size() > 0;
        e_dec_pc    = e_dec_valid ? mq[0] : '0;
        e_dec_instr = e_dec_valid ? instr_of(mq[0]) : '0;
        o_req_valid = imem_req_valid;
        o_req_addr  = imem_req_addr;
        o_dec_valid = dec_valid;
        o_dec_pc    = dec_pc;
        o_dec_instr = dec_instr;
        o_accept    = imem_req_valid && imem_req_ready;
        o_pop       = dec_valid && dec_ready && !redirect_valid;
        o_rsp       = imem_rsp_valid;
        accept_m = e_req_valid && imem_req_ready;
        pop_m    = e_dec_valid && dec_ready && !redirect_valid;
        push_m   = imem_rsp_valid && (mem_epoch == epoch) && !redirect_valid;
        if (pop_m) m_fetched++;
        if (e_dec_valid && !dec_ready) m_stall++;
        if (redirect_valid) begin
            mq.delete();
            epoch   = epoch + 1;
            exp_req = redirect_pc & ~64'h3;
        end else begin
            if (pop_m)    void'(mq.pop_front());
            if (push_m)   mq.push_back(mem_exp_pc);
            if (accept_m) exp_req = exp_req + 64'd4;
        end
        if (imem_rsp_valid) mem_busy = 1'b0;
        if (o_accept) begin
            mem_busy   = 1'b1;
            mem_cnt    = lat - 1;
            mem_addr   = o_req_addr;
            mem_exp_pc = e_req_addr;
            mem_epoch  = epoch;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        tests_run += 4;
        if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid got %0b want 0", imem_req_valid); end
        if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dec_valid got %0b want 0", dec_valid); end
        if (dec_pc !== '0) begin tests_failed++; $display("FAIL reset_dec_pc got %h want 0", dec_pc); end
        if (dec_instr !== '0) begin tests_failed++; $display("FAIL reset_dec_instr got %h want 0", dec_instr); end
`ifdef FETCH_PERF_COUNTERS_EN
        tests_run++;
        if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
            tests_failed++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_fetched, perf_stall);
        end
`endif
        do_reset();
    endtask

    task automatic test_basic();
        logic [63:0] acc[$];
        logic [63:0] pcs[$];
        logic [31:0] ins[$];
        int          pidx[$];
        do_reset();
        lat = 1; dec_ready = 1'b1; imem_req_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) begin
                tests_run++;
                if (o_req_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_first_req got %0b want 1", o_req_valid); end
            end
            if (o_accept) acc.push_back(o_req_addr);
            if (o_pop) begin pcs.push_back(o_dec_pc); ins.push_back(o_dec_instr); pidx.push_back(i); end
        end
        tests_run++;
        if (acc.size() < 3 || pcs.size() < 2) begin
            tests_failed++; $display("FAIL basic_counts got acc=%0d pops=%0d want >=3/>=2", acc.size(), pcs.size());
        end else begin
            tests_run += 7;
            if (acc[0] !== 64'h0) begin tests_failed++; $display("FAIL basic_addr0 got %h want 0", acc[0]); end
            if (acc[1] !== 64'h4) begin tests_failed++; $display("FAIL basic_addr1 got %h want 4", acc[1]); end
            if (acc[2] !== 64'h8) begin tests_failed++; $display("FAIL basic_addr2 got %h want 8", acc[2]); end
            if (pcs[0] !== 64'h0) begin tests_failed++; $display("FAIL basic_pc0 got %h want 0", pcs[0]); end
            if (ins[0] !== 32'h0000_0013) begin tests_failed++; $display("FAIL basic_instr0 got %h want 00000013", ins[0]); end
            if (pcs[1] !== 64'h4) begin tests_failed++; $display("FAIL basic_pc1 got %h want 4", pcs[1]); end
            if (pidx[0] !== 2 || pidx[1] - pidx[0] !== 2) begin
                tests_failed++; $display("FAIL basic_timing got first=%0d gap=%0d want 2/2", pidx[0], pidx[1] - pidx[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        dec_ready = 1'b0;
        for (int i = 0; i < 20 && mq.size() != 3; i++) step();
        tests_run++;
        if (mq.size() != 3) begin tests_failed++; $display("FAIL midrst_fill got %0d want 3", mq.size()); end
        #2; rst = 1'b1; #1;
        tests_run += 2;
        if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_req_valid got %0b want 0", imem_req_valid); end
        if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_dec_valid got %0b want 0", dec_valid); end
`ifdef FETCH_PERF_COUNTERS_EN
        tests_run++;
        if (perf_fetched !== 32'd0) begin tests_failed++; $display("FAIL midrst_perf got %0d want 0", perf_fetched); end
`endif
        do_reset();
    endtask

    task automatic test_backpressure();
        int          n_acc;
        logic [63:0] pcs[$];
        do_reset();
        lat = 1; dec_ready = 1'b0; imem_req_ready = 1'b1; n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_accept) n_acc++;
        end
        tests_run += 4;
        if (n_acc !== DEPTH) begin tests_failed++; $display("FAIL bp_accepts got %0d want %0d", n_acc, DEPTH); end
        if (o_req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_req_valid got %0b want 0", o_req_valid); end
        if (o_dec_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_dec_valid got %0b want 1", o_dec_valid); end
        if (o_dec_pc !== 64'h0) begin tests_failed++; $display("FAIL bp_head_pc got %h want 0", o_dec_pc); end
        dec_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_pop) pcs.push_back(o_dec_pc);
        end
        tests_run++;
        if (pcs.size() < 4) begin
            tests_failed++; $display("FAIL bp_drain_count got %0d want >=4", pcs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (pcs[k] !== 64'(4 * k)) begin tests_failed++; $display("FAIL bp_drain_pc%0d got %h want %h", k, pcs[k], 64'(4 * k)); end
            end
        end
    endtask

    task automatic test_redirect_outstanding();
        int          rsp_idx, acc_idx;
        logic [63:0] acc_addr, pop_pc;
        logic [31:0] pop_instr;
        do_reset();
        lat = 3; dec_ready = 1'b1; imem_req_ready = 1'b1;
        rsp_idx = -1; acc_idx = -1; pop_pc = '1; pop_instr = '0; acc_addr = '1;
        step();
        redirect_valid = 1'b1; redirect_pc = 64'h1003;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (o_rsp && rsp_idx < 0) rsp_idx = i;
            if (o_accept && acc_idx < 0) begin acc_idx = i; acc_addr = o_req_addr; end
            if (o_pop && pop_pc === '1) begin pop_pc = o_dec_pc; pop_instr = o_dec_instr; end
        end
        tests_run += 4;
        if (rsp_idx < 0 || acc_idx !== rsp_idx + 1) begin
            tests_failed++; $display("FAIL redir_issue_time got acc=%0d rsp=%0d want acc=rsp+1", acc_idx, rsp_idx);
        end
        if (acc_addr !== 64'h1000) begin tests_failed++; $display("FAIL redir_req_addr got %h want 1000", acc_addr); end
        if (pop_pc !== 64'h1000) begin tests_failed++; $display("FAIL redir_first_pc got %h want 1000", pop_pc); end
        if (pop_instr !== instr_of(64'h1000)) begin
            tests_failed++; $display("FAIL redir_first_instr got %h want %h", pop_instr, instr_of(64'h1000));
        end
    endtask

    task automatic test_redirect_with_rsp();
        bit found;
        do_reset();
        lat = 2; dec_ready = 1'b0; imem_req_ready = 1'b1; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_busy && mem_cnt == 0 && mq.size() > 0) begin
                redirect_valid = 1'b1; redirect_pc = 64'h2000; dec_ready = 1'b1;
                step();
                redirect_valid = 1'b0;
                found = 1'b1;
            end else begin
                step();
            end
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL redir_rsp_setup got none want rsp with queued entry"); end
        step();
        tests_run += 3;
        if (o_dec_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_rsp_dec_valid got %0b want 0", o_dec_valid); end
        if (o_req_valid !== 1'b1) begin tests_failed++; $display("FAIL redir_rsp_req_valid got %0b want 1", o_req_valid); end
        if (o_req_addr !== 64'h2000) begin tests_failed++; $display("FAIL redir_rsp_req_addr got %h want 2000", o_req_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        w_dec_ready = 1'b1; w_req_ready = 1'b1;
        @(negedge clk); #1;
        tests_run += 2;
        if (w_req_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_req0_valid got %0b want 1", w_req_valid); end
        if (w_req_addr !== WRAP_PC) begin tests_failed++; $display("FAIL wrap_req0_addr got %h want %h", w_req_addr, WRAP_PC); end
        @(posedge clk); #1;
        @(negedge clk);
        w_rsp_valid = 1'b1; w_rsp_instr = instr_of(WRAP_PC);
        #1;
        tests_run++;
        if (w_req_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_outstanding got %0b want 0", w_req_valid); end
        @(posedge clk); #1;
        w_rsp_valid = 1'b0;
        @(negedge clk); #1;
        tests_run += 3;
        if (w_req_valid !== 1'b1 || w_req_addr !== 64'h0) begin
            tests_failed++; $display("FAIL wrap_req1 got v=%0b addr=%h want v=1 addr=0", w_req_valid, w_req_addr);
        end
        if (w_dec_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_dec_valid got %0b want 1", w_dec_valid); end
        if (w_dec_pc !== WRAP_PC) begin tests_failed++; $display("FAIL wrap_dec_pc got %h want %h", w_dec_pc, WRAP_PC); end
        w_req_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            dec_ready      = ($urandom_range(0, 9) < 7);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            lat            = $urandom_range(1, 4);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom_range(0, 1) ? 64'($urandom_range(0, 255)) : {32'($urandom), 32'($urandom)};
            step();
            tests_run += 2;
            if (o_req_valid !== e_req_valid) begin
                tests_failed++; $display("FAIL rnd_req_valid cyc=%0d got %0b want %0b", i, o_req_valid, e_req_valid);
            end
            if (o_dec_valid !== e_dec_valid) begin
                tests_failed++; $display("FAIL rnd_dec_valid cyc=%0d got %0b want %0b", i, o_dec_valid, e_dec_valid);
            end
            if (e_req_valid) begin
                tests_run++;
                if (o_req_addr !== e_req_addr) begin
                    tests_failed++; $display("FAIL rnd_req_addr cyc=%0d got %h want %h", i, o_req_addr, e_req_addr);
                end
            end
            if (e_dec_valid) begin
                tests_run++;
                if (o_dec_pc !== e_dec_pc || o_dec_instr !== e_dec_instr) begin
                    tests_failed++; $display("FAIL rnd_dec_head cyc=%0d got %h/%h want %h/%h", i, o_dec_pc, o_dec_instr, e_dec_pc, e_dec_instr);
                end
            end
        end
        redirect_valid = 1'b0;
`ifdef FETCH_PERF_COUNTERS_EN
        tests_run += 2;
        if (perf_fetched !== m_fetched) begin tests_failed++; $display("FAIL rnd_perf_fetched got %0d want %0d", perf_fetched, m_fetched); end
        if (perf_stall !== m_stall) begin tests_failed++; $display("FAIL rnd_perf_stall got %0d want %0d", perf_stall, m_stall); end
`endif
    endtask

    initial begin
        epoch = 0;
        test_reset();
        test_basic();
        test_reset_mid();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_with_rsp();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction-fetch stage with a prefetch queue. It keeps the fetch PC and issues in-order word requests to instruction memory over a valid/ready interface. Returned instructions are buffered with their PCs in a DEPTH-entry FIFO, and decode consumes them through a valid/ready handshake. Branch/jump redirects from decode or execute flush the queue, and any in-flight response is dropped.

## Interface
- XLEN, 64, address/PC width
- ILEN, 32, instruction width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, '0, PC loaded on reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  redirect request; highest priority
- redirect_pc  in  XLEN  target; bits [1:0] are forced to 0
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word address (bits [1:0] = 0)
- imem_rsp_valid  in  1  response, in order, ≥1 cycle after acceptance
- imem_rsp_instr  in  ILEN  returned instruction
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decode accepts head
- dec_pc  out  XLEN  PC of head
- dec_instr  out  ILEN  instruction of head
- perf_fetched  out  32  instructions handed to decode (FETCH_PERF_COUNTERS_EN only)
- perf_stall  out  32  cycles with dec_valid & !dec_ready (FETCH_PERF_COUNTERS_EN only)

## Operation
- State: fetch_pc, outstanding flag, drop flag, FIFO (wr/rd pointers of log2(DEPTH)+1 bits), count.
- Reset values: fetch_pc = RESET_PC, outstanding = 0, drop = 0, FIFO empty, dec_valid = 0, imem_req_valid = 0, dec_pc/dec_instr = 0, perf counters = 0.
- At most one request is outstanding.
- Issue: imem_req_valid = !redirect_valid & !outstanding & (count < DEPTH). imem_req_addr = fetch_pc.
- Request accept (valid & ready): outstanding <= 1, fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
- Response: outstanding <= 0.
  - If drop = 1: discard the response and clear drop.
  - Else: push {req_pc, imem_rsp_instr}, where req_pc is the address latched at acceptance.
- A response and a new acceptance in the same cycle are illegal by construction, because issue requires !outstanding.
- Pop: dec_valid & dec_ready advances rd. Push and pop in the same cycle leave count unchanged. A push arriving when count == DEPTH cannot occur, because the issue rule reserves the slot.
- Redirect (cycle t):
  - FIFO is cleared and fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Any accept, push or pop in cycle t is void.
  - drop <= outstanding & !imem_rsp_valid.
- Reset asserted mid-operation clears all state immediately. A later stray response with outstanding = 0 is ignored.

## Timing
- After reset deasserts, imem_req_valid = 1 in the first cycle with addr = RESET_PC.
- Memory latency L (accept → rsp_valid): entry visible on dec_valid the cycle after rsp_valid (registered FIFO, no bypass).
- Steady-state throughput: one instruction per L+1 cycles.
- Redirect at edge t: dec_valid = 0 from t+1.
  - With no drop pending, a request for the target is issued at t+1.
  - With a drop pending, the request for the target is issued the cycle after the stale response.
- dec_* outputs are stable while dec_valid & !dec_ready.

## Configuration
- FETCH_PERF_COUNTERS_EN defined: perf_fetched and perf_stall ports and their counters exist. Both are 32-bit, wrap on overflow, and are not cleared by redirect, only by rst.
- FETCH_PERF_COUNTERS_EN undefined: ports and logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg holds:
  - fetch_entry_t struct {pc, instr}
  - INSTR_BYTES = 4
  - PC_ALIGN_MASK
- One sub-module, fetch_queue: a parametrised synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty.

## Test plan
- Reset release, memory L=1, dec_ready=1 → requests at 0x0, 0x4, 0x8; decode sees pc 0x0 / instr 0x00000013 first, then 0x4, in order.
- dec_ready=0 for 20 cycles, DEPTH=4 → exactly 4 entries are queued, then imem_req_valid stays 0. Raising dec_ready drains pcs 0x0–0xC in order.
- Redirect to 0x1003 while a request is outstanding (L=3) → stale response is dropped; next req_addr = 0x1000; first dec_pc = 0x1000.
- Redirect in the same cycle as rsp_valid and dec_ready → queue empty next cycle, no drop pending, req for target issued at t+1.
- RESET_PC = 0xFFFF_FFFF_FFFF_FFFC, XLEN=64 → second request address wraps to 0x0.
- rst asserted mid-stream with queue at 3 entries → dec_valid = 0 and imem_req_valid = 0 immediately. With the macro defined, perf_fetched = 0.
